eic_prio_sched: RTL and testbench

Priority scheduler between the external interrupt sources and the core. Latches one-cycle interrupt pulses into pending bits, applies a per-source enable and priority plus a global threshold, and presents a single level interrupt to the core. Software obtains the winning source ID through a claim read and releases it through a complete write. The block is a bus slave on the peripheral bus, using the same access and fault protocol as the other femto peripherals.

---
 rtl/eic_prio_sched_pkg.sv | 33 +++
 rtl/eic_prio_sched_if.sv | 22 ++
 rtl/eic_prio_select.sv | 63 ++++++
 rtl/eic_prio_sched.sv | 137 +++++++++++++
 tb/tb_eic_prio_sched.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eic_prio_sched_pkg.sv
// Shared constants, FSM encoding and bus helpers for the external interrupt
// priority scheduler.
package eic_prio_sched_pkg;

    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    localparam int EXT_INT_SRC_NUM = 8;
    localparam int EPS_PRIO_WIDTH  = 3;
    localparam int EPS_ID_WIDTH    = 3;
    localparam int EPS_VA_WIDTH    = 4;

    localparam logic [EPS_VA_WIDTH-1:0] EPS_ENABLE = 4'h0;
    localparam logic [EPS_VA_WIDTH-1:0] EPS_PRIO   = 4'h4;
    localparam logic [EPS_VA_WIDTH-1:0] EPS_THRESH = 4'h8;
    localparam logic [EPS_VA_WIDTH-1:0] EPS_CLAIM  = 4'hC;

    typedef enum logic [1:0] {
        EPS_IDLE    = 2'd0,
        EPS_NOTIFY  = 2'd1,
        EPS_SERVICE = 2'd2
    } eps_state_t;

    // Only aligned word accesses are legal in this block.
    function automatic logic acc_legal(input logic [BUS_ACC_WIDTH-1:0] acc,
                                       input logic [1:0] addr_lsb);
        return (acc == BUS_ACC_4B) && (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/eic_prio_sched_if.sv
// Peripheral bus port of the interrupt scheduler.
interface eic_prio_sched_if;
    import eic_prio_sched_pkg::*;

    // req is a single-cycle request; a legal access is always accepted and
    // answered by resp (with rdata) in the following cycle, an illegal one
    // raises fault combinationally in the request cycle and gets no resp.
    logic [EPS_VA_WIDTH-1:0]  addr;
    logic                     w_rb;
    logic [BUS_ACC_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH-1:0]     rdata;
    logic                     req;
    logic                     resp;
    logic                     fault;

    modport master (output addr, w_rb, acc, wdata, req,
                    input  rdata, resp, fault);
    modport slave  (input  addr, w_rb, acc, wdata, req,
                    output rdata, resp, fault);

endinterface

// File: rtl/eic_prio_select.sv
// Combinational winner tree: highest priority among eligible sources, ties to
// the lower index. Padded to eight leaves.
module eic_prio_select
    import eic_prio_sched_pkg::*;
#(
    parameter int SRC_NUM    = EXT_INT_SRC_NUM,
    parameter int PRIO_WIDTH = EPS_PRIO_WIDTH
) (
    input  logic [SRC_NUM-1:0]            eligible,
    input  logic [SRC_NUM*PRIO_WIDTH-1:0] prio,
    output logic [EPS_ID_WIDTH-1:0]       win_idx,
    output logic                          win_valid,
    output logic [PRIO_WIDTH-1:0]         win_prio
);

    localparam int LEAVES = 8;
    typedef logic [PRIO_WIDTH-1:0] prio_t;

    logic  l3_v [LEAVES];
    prio_t l3_p [LEAVES];
    logic [2:0] l3_i [LEAVES];
    logic  l2_v [4];
    prio_t l2_p [4];
    logic [2:0] l2_i [4];
    logic  l1_v [2];
    prio_t l1_p [2];
    logic [2:0] l1_i [2];
    logic  root_take_r;

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < SRC_NUM) begin : g_src
            assign l3_v[i] = eligible[i];
            assign l3_p[i] = prio[i*PRIO_WIDTH +: PRIO_WIDTH];
        end else begin : g_pad
            assign l3_v[i] = 1'b0;
            assign l3_p[i] = '0;
        end
        assign l3_i[i] = 3'(i);
    end

    // The right child only wins with a strictly higher priority.
    for (genvar k = 0; k < 4; k++) begin : g_l2
        logic take_r;
        assign take_r  = l3_v[2*k+1] && (!l3_v[2*k] || (l3_p[2*k+1] > l3_p[2*k]));
        assign l2_v[k] = l3_v[2*k] | l3_v[2*k+1];
        assign l2_p[k] = take_r ? l3_p[2*k+1] : l3_p[2*k];
        assign l2_i[k] = take_r ? l3_i[2*k+1] : l3_i[2*k];
    end

    for (genvar k = 0; k < 2; k++) begin : g_l1
        logic take_r;
        assign take_r  = l2_v[2*k+1] && (!l2_v[2*k] || (l2_p[2*k+1] > l2_p[2*k]));
        assign l1_v[k] = l2_v[2*k] | l2_v[2*k+1];
        assign l1_p[k] = take_r ? l2_p[2*k+1] : l2_p[2*k];
        assign l1_i[k] = take_r ? l2_i[2*k+1] : l2_i[2*k];
    end

    assign root_take_r = l1_v[1] && (!l1_v[0] || (l1_p[1] > l1_p[0]));
    assign win_valid   = l1_v[0] | l1_v[1];
    assign win_prio    = root_take_r ? l1_p[1] : l1_p[0];
    assign win_idx     = root_take_r ? l1_i[1] : l1_i[0];

endmodule

// File: rtl/eic_prio_sched.sv
// Interrupt priority scheduler: latches source pulses, gates them by enable,
// priority and threshold, and runs the notify/claim/complete handshake.
module eic_prio_sched
    import eic_prio_sched_pkg::*;
#(
    parameter int SRC_NUM    = EXT_INT_SRC_NUM,
    parameter int PRIO_WIDTH = EPS_PRIO_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SRC_NUM-1:0] src_pulse,
    output logic               irq,
    eic_prio_sched_if.slave    bus,
    output eps_state_t         dbg_state,
    output logic [SRC_NUM-1:0] dbg_pend
);

    localparam int PW_ALL = SRC_NUM * PRIO_WIDTH;

    eps_state_t                state;
    logic [SRC_NUM-1:0]        enable;
    logic [PW_ALL-1:0]         prio;
    logic [PRIO_WIDTH-1:0]     thresh;
    logic [SRC_NUM-1:0]        pend;
    logic [EPS_ID_WIDTH-1:0]   act_id;

    logic [SRC_NUM-1:0]        eligible;
    logic [EPS_ID_WIDTH-1:0]   win_idx;
    logic                      win_valid;
    logic [PRIO_WIDTH-1:0]     win_prio;
    logic                      acc_ok, rd, wr;
    logic                      claim_rd, claim_hit, complete_hit;
    logic [SRC_NUM-1:0]        claim_clr;
    logic [3:0]                claim_id;
    logic                      unused_bits;

    assign acc_ok    = bus.req && acc_legal(bus.acc, bus.addr[1:0]);
    assign bus.fault = bus.req && !acc_legal(bus.acc, bus.addr[1:0]);
    assign rd        = acc_ok && !bus.w_rb;
    assign wr        = acc_ok && bus.w_rb;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            eligible[i] = pend[i] && enable[i] && (prio[i*PRIO_WIDTH +: PRIO_WIDTH] > thresh);
        end
    end

    eic_prio_select #(.SRC_NUM(SRC_NUM), .PRIO_WIDTH(PRIO_WIDTH)) u_select (
        .eligible  (eligible),
        .prio      (prio),
        .win_idx   (win_idx),
        .win_valid (win_valid),
        .win_prio  (win_prio)
    );

    // A claim read outside NOTIFY, or with nothing eligible, returns 0.
    assign claim_rd     = rd && (bus.addr == EPS_CLAIM) && (state == EPS_NOTIFY);
    assign claim_hit    = claim_rd && win_valid;
    assign claim_clr    = claim_hit ? (SRC_NUM'(1) << win_idx) : '0;
    assign claim_id     = 4'(win_idx) + 4'd1;
    assign complete_hit = wr && (bus.addr == EPS_CLAIM) && (state == EPS_SERVICE)
                          && (bus.wdata[3:0] == (4'(act_id) + 4'd1));
    assign unused_bits  = ^{bus.wdata, win_prio};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EPS_IDLE;
            irq   <= 1'b0;
        end else begin
            case (state)
                EPS_IDLE: begin
                    irq <= win_valid;
                    if (win_valid) state <= EPS_NOTIFY;
                end
                EPS_NOTIFY: begin
                    if (claim_rd) begin
                        state <= win_valid ? EPS_SERVICE : EPS_IDLE;
                        irq   <= 1'b0;
                    end else if (!win_valid) begin
                        state <= EPS_IDLE;
                        irq   <= 1'b0;
                    end else begin
                        irq   <= 1'b1;
                    end
                end
                EPS_SERVICE: begin
                    irq <= 1'b0;
                    if (complete_hit) state <= EPS_IDLE;
                end
                default: begin
                    state <= EPS_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable    <= '0;
            prio      <= '0;
            thresh    <= '0;
            pend      <= '0;
            act_id    <= '0;
            bus.resp  <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.resp  <= acc_ok;
            bus.rdata <= '0;
            if (rd) begin
                case (bus.addr)
                    EPS_ENABLE: bus.rdata <= BUS_WIDTH'(enable);
                    EPS_PRIO:   bus.rdata <= BUS_WIDTH'(prio);
                    EPS_THRESH: bus.rdata <= BUS_WIDTH'(thresh);
                    EPS_CLAIM:  bus.rdata <= claim_hit ? BUS_WIDTH'(claim_id) : '0;
                    default:    bus.rdata <= '0;
                endcase
            end
            if (wr) begin
                case (bus.addr)
                    EPS_ENABLE: enable <= bus.wdata[SRC_NUM-1:0];
                    EPS_PRIO:   prio   <= bus.wdata[PW_ALL-1:0];
                    EPS_THRESH: thresh <= bus.wdata[PRIO_WIDTH-1:0];
                    default: ;
                endcase
            end
            // A new pulse on the claimed source survives the claim.
            pend <= (pend & ~claim_clr) | src_pulse;
            if (claim_hit) act_id <= win_idx;
        end
    end

    assign dbg_state = state;
    assign dbg_pend  = pend;

endmodule

// File: tb/tb_eic_prio_sched.sv
// Bench for eic_prio_sched: directed table, hand-written corner sequences and
// random traffic compared against a spec-level model.
module tb_eic_prio_sched;
    import eic_prio_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src_pulse;
    logic       irq;
    eps_state_t dbg_state;
    logic [7:0] dbg_pend;

    eic_prio_sched_if bus();

    eic_prio_sched #(.SRC_NUM(8), .PRIO_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_pulse (src_pulse),
        .irq       (irq),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_pend  (dbg_pend)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: registers, pending flags and handshake phase
    // (0 = waiting, 1 = notifying, 2 = in service).
    logic [7:0]  m_en;
    logic [7:0]  m_pend;
    int          m_prio [8];
    int          m_th;
    int          m_mode;
    int          m_act;
    logic        last_fault;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [7:0]  pulse;
        logic        req;
        logic        w;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        irq;
        logic        resp;
        logic [31:0] rdata;
        logic [7:0]  pend;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_winner();
        int best = -1;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && m_en[i] && (m_prio[i] > m_th)) begin
                if (best < 0 || m_prio[i] > m_prio[best]) best = i;
            end
        end
        return best;
    endfunction

    function automatic eps_state_t mode_enc(input int mode);
        case (mode)
            1:       return EPS_NOTIFY;
            2:       return EPS_SERVICE;
            default: return EPS_IDLE;
        endcase
    endfunction

    task automatic m_reset();
        m_en   = '0;
        m_pend = '0;
        for (int i = 0; i < 8; i++) m_prio[i] = 0;
        m_th   = 0;
        m_mode = 0;
        m_act  = 0;
        exp_q.delete();
    endtask

    // One bus cycle: drive at the falling edge, check fault, advance the model,
    // check registered outputs just after the rising edge.
    task automatic step(input logic [7:0] pulse, input logic req, input logic w,
                        input logic [3:0] a, input logic [1:0] ac, input logic [31:0] wd);
        int          win;
        int          nmode;
        logic        valid, ok, rd, wr, claim;
        logic [31:0] e_rd, pk;
        src_pulse = pulse;
        bus.req   = req;
        bus.w_rb  = w;
        bus.addr  = a;
        bus.acc   = ac;
        bus.wdata = wd;
        #1;
        valid      = (ac == BUS_ACC_4B) && (a[1:0] == 2'b00);
        last_fault = bus.fault;
        chk("fault", 32'(bus.fault), 32'(req && !valid));
        win   = m_winner();
        ok    = req && valid;
        rd    = ok && !w;
        wr    = ok && w;
        pk    = '0;
        for (int i = 0; i < 8; i++) pk = pk | (32'(m_prio[i]) << (3 * i));
        e_rd  = '0;
        claim = 1'b0;
        if (rd) begin
            case (a)
                4'h0: e_rd = 32'(m_en);
                4'h4: e_rd = pk;
                4'h8: e_rd = 32'(m_th);
                4'hC: if (m_mode == 1 && win >= 0) begin
                    e_rd  = 32'(win + 1);
                    claim = 1'b1;
                end
                default: ;
            endcase
        end
        exp_q.push_back(e_rd);
        nmode = m_mode;
        case (m_mode)
            0: if (win >= 0) nmode = 1;
            1: begin
                if (rd && a == 4'hC) nmode = (win >= 0) ? 2 : 0;
                else if (win < 0) nmode = 0;
            end
            2: if (wr && a == 4'hC && wd[3:0] == 4'(m_act + 1)) nmode = 0;
            default: nmode = 0;
        endcase
        if (claim) begin
            m_act        = win;
            m_pend[win]  = 1'b0;
        end
        m_pend = m_pend | pulse;
        if (wr) begin
            case (a)
                4'h0: m_en = wd[7:0];
                4'h4: for (int i = 0; i < 8; i++) m_prio[i] = int'((wd >> (3 * i)) & 32'd7);
                4'h8: m_th = int'(wd[2:0]);
                default: ;
            endcase
        end
        m_mode = nmode;
        @(posedge clk);
        #1;
        chk("irq",   32'(irq),       32'(m_mode == 1));
        chk("resp",  32'(bus.resp),  32'(ok));
        chk("rdata", bus.rdata,      exp_q.pop_front());
        chk("state", 32'(dbg_state), 32'(mode_enc(m_mode)));
        chk("pend",  32'(dbg_pend),  32'(m_pend));
        @(negedge clk);
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 4'h0, BUS_ACC_4B, 32'h0);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        step(8'h00, 1'b1, 1'b1, a, BUS_ACC_4B, d);
    endtask

    task automatic rd_reg(input logic [3:0] a);
        step(8'h00, 1'b1, 1'b0, a, BUS_ACC_4B, 32'h0);
    endtask

    task automatic pulse(input logic [7:0] p);
        step(p, 1'b0, 1'b0, 4'h0, BUS_ACC_4B, 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        src_pulse = '0;
        bus.req   = 1'b0;
        bus.w_rb  = 1'b0;
        bus.addr  = '0;
        bus.acc   = BUS_ACC_4B;
        bus.wdata = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_irq",   32'(irq),       32'd0);
        chk("rst_resp",  32'(bus.resp),  32'd0);
        chk("rst_rdata", bus.rdata,      32'd0);
        chk("rst_pend",  32'(dbg_pend),  32'd0);
        chk("rst_state", 32'(dbg_state), 32'(EPS_IDLE));
        rst = 1'b0;

        // Tie-break and claim: sources 5 and 2 at equal priority.
        tbl[0]  = '{8'h00, 1'b1, 1'b1, 4'h0, 32'hFF,     1'b0, 1'b1, 32'd0, 8'h00};
        tbl[1]  = '{8'h00, 1'b1, 1'b1, 4'h4, 32'h6DB6DB, 1'b0, 1'b1, 32'd0, 8'h00};
        tbl[2]  = '{8'h00, 1'b1, 1'b1, 4'h8, 32'h0,      1'b0, 1'b1, 32'd0, 8'h00};
        tbl[3]  = '{8'h24, 1'b0, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'd0, 8'h24};
        tbl[4]  = '{8'h00, 1'b0, 1'b0, 4'h0, 32'h0,      1'b1, 1'b0, 32'd0, 8'h24};
        tbl[5]  = '{8'h00, 1'b1, 1'b0, 4'hC, 32'h0,      1'b0, 1'b1, 32'd3, 8'h20};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'd0, 8'h20};
        tbl[7]  = '{8'h00, 1'b1, 1'b1, 4'hC, 32'h3,      1'b0, 1'b1, 32'd0, 8'h20};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 4'h0, 32'h0,      1'b1, 1'b0, 32'd0, 8'h20};
        tbl[9]  = '{8'h00, 1'b1, 1'b0, 4'hC, 32'h0,      1'b0, 1'b1, 32'd6, 8'h00};
        tbl[10] = '{8'h00, 1'b1, 1'b1, 4'hC, 32'h6,      1'b0, 1'b1, 32'd0, 8'h00};
        tbl[11] = '{8'h00, 1'b0, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'd0, 8'h00};
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].pulse, tbl[k].req, tbl[k].w, tbl[k].addr, BUS_ACC_4B, tbl[k].wdata);
            chk($sformatf("tbl%0d_irq", k),   32'(irq),      32'(tbl[k].irq));
            chk($sformatf("tbl%0d_resp", k),  32'(bus.resp), 32'(tbl[k].resp));
            chk($sformatf("tbl%0d_rdata", k), bus.rdata,     tbl[k].rdata);
            chk($sformatf("tbl%0d_pend", k),  32'(dbg_pend), 32'(tbl[k].pend));
        end

        // Threshold masking: priority equal to the threshold never notifies.
        wr_reg(4'h4, 32'h10);
        wr_reg(4'h8, 32'h2);
        pulse(8'h02);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("thr_masked", 32'(irq), 32'd0);
        end
        wr_reg(4'h8, 32'h1);
        chk("thr_irq_n1", 32'(irq), 32'd0);
        idle();
        chk("thr_irq_n2", 32'(irq), 32'd1);
        rd_reg(4'hC);
        chk("thr_claim", bus.rdata, 32'd2);
        wr_reg(4'hC, 32'h2);

        // No nesting: a higher-priority source waits for the complete.
        wr_reg(4'h4, 32'hE00001);
        wr_reg(4'h8, 32'h0);
        pulse(8'h01);
        idle();
        rd_reg(4'hC);
        chk("blk_claim0", bus.rdata, 32'd1);
        chk("blk_service", 32'(dbg_state), 32'(EPS_SERVICE));
        pulse(8'h80);
        idle();
        idle();
        chk("blk_irq_low", 32'(irq), 32'd0);
        rd_reg(4'hC);
        chk("blk_claim_svc", bus.rdata, 32'd0);
        chk("blk_claim_resp", 32'(bus.resp), 32'd1);
        wr_reg(4'hC, 32'h1);
        chk("blk_irq_n1", 32'(irq), 32'd0);
        idle();
        chk("blk_irq_n2", 32'(irq), 32'd1);
        rd_reg(4'hC);
        chk("blk_claim7", bus.rdata, 32'd8);
        wr_reg(4'hC, 32'h8);

        // Wrong complete and faulting accesses.
        wr_reg(4'h4, 32'hA00);
        pulse(8'h08);
        idle();
        rd_reg(4'hC);
        chk("wc_claim", bus.rdata, 32'd4);
        wr_reg(4'hC, 32'h3);
        chk("wc_resp", 32'(bus.resp), 32'd1);
        chk("wc_state", 32'(dbg_state), 32'(EPS_SERVICE));
        step(8'h00, 1'b1, 1'b0, 4'h0, BUS_ACC_1B, 32'h0);
        chk("byte_fault", 32'(last_fault), 32'd1);
        chk("byte_resp", 32'(bus.resp), 32'd0);
        step(8'h00, 1'b1, 1'b0, 4'h2, BUS_ACC_4B, 32'h0);
        chk("unal_fault", 32'(last_fault), 32'd1);
        chk("unal_resp", 32'(bus.resp), 32'd0);
        step(8'h00, 1'b1, 1'b1, 4'h0, BUS_ACC_2B, 32'h0);
        chk("half_wr_fault", 32'(last_fault), 32'd1);
        wr_reg(4'hC, 32'h4);
        chk("wc_done", 32'(dbg_state), 32'(EPS_IDLE));

        // Notify withdrawal, then asynchronous reset mid-service.
        pulse(8'h08);
        idle();
        chk("wd_irq", 32'(irq), 32'd1);
        wr_reg(4'h0, 32'h0);
        idle();
        chk("wd_irq_dropped", 32'(irq), 32'd0);
        wr_reg(4'h0, 32'hFF);
        idle();
        chk("wd_irq_back", 32'(irq), 32'd1);
        rd_reg(4'hC);
        chk("wd_claim", bus.rdata, 32'd4);
        step(8'h40, 1'b1, 1'b0, 4'h0, BUS_ACC_4B, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_irq",   32'(irq),       32'd0);
        chk("arst_resp",  32'(bus.resp),  32'd0);
        chk("arst_rdata", bus.rdata,      32'd0);
        chk("arst_pend",  32'(dbg_pend),  32'd0);
        chk("arst_state", 32'(dbg_state), 32'(EPS_IDLE));
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        rd_reg(4'h0);
        chk("arst_enable", bus.rdata, 32'd0);
        rd_reg(4'h4);
        chk("arst_prio", bus.rdata, 32'd0);
        rd_reg(4'h8);
        chk("arst_thresh", bus.rdata, 32'd0);

        // Random traffic against the model.
        wr_reg(4'h0, 32'($urandom));
        wr_reg(4'h4, 32'($urandom));
        for (int n = 0; n < 1500; n++) begin
            logic [7:0]  p;
            logic [31:0] d;
            int          kind;
            p = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            d = $urandom;
            if ($urandom_range(0, 9) < 4) begin
                step(p, 1'b0, 1'b0, 4'($urandom), 2'($urandom), d);
            end else begin
                kind = $urandom_range(0, 7);
                case (kind)
                    0: step(p, 1'b1, 1'b1, 4'h0, BUS_ACC_4B, d);
                    1: step(p, 1'b1, 1'b1, 4'h4, BUS_ACC_4B, d);
                    2: step(p, 1'b1, 1'b1, 4'h8, BUS_ACC_4B, d);
                    3, 4: step(p, 1'b1, 1'b0, 4'hC, BUS_ACC_4B, d);
                    5: step(p, 1'b1, 1'b1, 4'hC, BUS_ACC_4B,
                            ($urandom_range(0, 3) != 0) ? 32'(m_act + 1) : d);
                    6: step(p, 1'b1, 1'b0, 4'($urandom_range(0, 2) * 4), BUS_ACC_4B, d);
                    default: step(p, 1'b1, 1'($urandom), 4'($urandom), 2'($urandom), d);
                endcase
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
